// File: rtl/ram_arbiter_2req.sv
// Round-robin arbiter sharing one single-port no-change RAM between two requesters.
// Optional power-up clear of the whole RAM is enabled with `define RAM_ARB_CLEAR_EN.
module ram_arbiter_2req #(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024,
    parameter int RD_LAT    = 2,
    localparam int ADDR_W   = (RAM_DEPTH > 2) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_we,
    input  logic [ADDR_W-1:0]    req_addr0,
    input  logic [ADDR_W-1:0]    req_addr1,
    input  logic [RAM_WIDTH-1:0] req_wdata0,
    input  logic [RAM_WIDTH-1:0] req_wdata1,
    output logic [1:0]           rsp_valid,
    output logic [RAM_WIDTH-1:0] rsp_data,
    output logic                 busy,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic                 ram_rsta,
    output logic                 ram_regcea,
    output logic [ADDR_W-1:0]    ram_addra,
    output logic [RAM_WIDTH-1:0] ram_dina,
    input  logic [RAM_WIDTH-1:0] ram_douta
);

`ifdef RAM_ARB_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
    logic [ADDR_W-1:0] r_clr_addr;
`else
    typedef enum logic {ST_RUN} state_t;
    localparam state_t RESET_STATE = ST_RUN;
`endif

    state_t               r_state;
    logic                 r_ptr;
    logic                 r_ena;
    logic                 r_wea;
    logic [ADDR_W-1:0]    r_addr;
    logic [RAM_WIDTH-1:0] r_din;
    logic [1:0]           r_tag [RD_LAT+1];

    logic                 w_run;
    logic [1:0]           w_gnt;
    logic                 w_sel;
    logic                 w_we;
    logic [ADDR_W-1:0]    w_addr;
    logic [RAM_WIDTH-1:0] w_wdata;
    logic [1:0]           w_rd_tag;

    assign w_run = (r_state == ST_RUN) && !rst;

    // r_ptr names the requester that wins when both are valid
    always_comb begin
        w_gnt    = 2'b00;
        w_gnt[0] = req_valid[0] & (~req_valid[1] | ~r_ptr);
        w_gnt[1] = req_valid[1] & (~req_valid[0] | r_ptr);
        if (!w_run) begin
            w_gnt = 2'b00;
        end
    end

    assign req_ready = w_gnt;
    assign w_sel     = w_gnt[1];
    assign w_we      = req_we[w_sel];
    assign w_addr    = w_sel ? req_addr1 : req_addr0;
    assign w_wdata   = w_sel ? req_wdata1 : req_wdata0;
    assign w_rd_tag  = w_gnt & ~req_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
            r_ptr   <= 1'b0;
            r_ena   <= 1'b0;
            r_wea   <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                r_tag[i] <= 2'b00;
            end
`ifdef RAM_ARB_CLEAR_EN
            r_clr_addr <= '0;
`endif
        end else begin
            // The tag pipeline lines each read up with the RAM output latency
            r_tag[0] <= w_rd_tag;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_ena <= 1'b0;
            r_wea <= 1'b0;
            case (r_state)
`ifdef RAM_ARB_CLEAR_EN
                ST_CLEAR: begin
                    r_ena      <= 1'b1;
                    r_wea      <= 1'b1;
                    r_addr     <= r_clr_addr;
                    r_din      <= '0;
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= ST_RUN;
                    end
                end
`endif
                ST_RUN: begin
                    if (|w_gnt) begin
                        r_ena  <= 1'b1;
                        r_wea  <= w_we;
                        r_addr <= w_addr;
                        r_din  <= w_wdata;
                        r_ptr  <= ~w_sel;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef RAM_ARB_CLEAR_EN
    assign busy = (r_state == ST_CLEAR);
`else
    assign busy = 1'b0;
`endif

    assign rsp_valid  = r_tag[RD_LAT];
    assign rsp_data   = ram_douta;
    assign ram_ena    = r_ena;
    assign ram_wea    = r_wea;
    assign ram_addra  = r_addr;
    assign ram_dina   = r_din;
    assign ram_rsta   = rst;
    assign ram_regcea = 1'b1;

endmodule

// File: tb/tb_ram_arbiter_2req.sv
// Randomised scoreboard bench for ram_arbiter_2req with a behavioural RAM model
// (HIGH_PERFORMANCE, no-change). Honours RAM_ARB_CLEAR_EN when defined.
module tb_ram_arbiter_2req;
    localparam int W     = 18;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
`ifdef RAM_ARB_CLEAR_EN
    localparam int CLEAR_CYCLES = DEPTH;
    localparam bit BUSY_IN_RST  = 1'b1;
`else
    localparam int CLEAR_CYCLES = 0;
    localparam bit BUSY_IN_RST  = 1'b0;
`endif

    typedef enum {M_IDLE, M_FILLW, M_FILLR, M_BOTH, M_GAPS, M_RAW, M_RD2, M_RD777} mode_t;
    typedef struct {
        logic [1:0]   tag;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_we = 2'b00;
    logic [AW-1:0] req_addr0 = '0;
    logic [AW-1:0] req_addr1 = '0;
    logic [W-1:0]  req_wdata0 = '0;
    logic [W-1:0]  req_wdata1 = '0;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          busy;
    logic          ram_ena;
    logic          ram_wea;
    logic          ram_rsta;
    logic          ram_regcea;
    logic [AW-1:0] ram_addra;
    logic [W-1:0]  ram_dina;
    logic [W-1:0]  ram_douta;

    ram_arbiter_2req #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_rsta(ram_rsta),
        .ram_regcea(ram_regcea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_douta(ram_douta)
    );

    always #5 clk = ~clk;

    // RAM model: address registered, output register enabled, no-change on write
    logic [W-1:0] mem [DEPTH] = '{default: '0};
    logic [W-1:0] ramData = '0;
    logic [W-1:0] doutReg = '0;
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea) mem[ram_addra] <= ram_dina;
            else         ramData <= mem[ram_addra];
        end
        if (ram_rsta)        doutReg <= '0;
        else if (ram_regcea) doutReg <= ramData;
    end
    assign ram_douta = doutReg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state
    logic [W-1:0] refMem [DEPTH] = '{default: '0};
    exp_t         sb[$];
    bit           refPtr = 1'b0;
    bit           prevAny = 1'b0;
    int           checks = 0;
    int           failures = 0;

    // Stimulus state
    mode_t         mode = M_IDLE;
    int            seq = 0;
    logic          cv [2] = '{1'b0, 1'b0};
    logic          cwe [2] = '{1'b0, 1'b0};
    logic [AW-1:0] caddr [2] = '{'0, '0};
    logic [W-1:0]  cdata [2] = '{'0, '0};
    logic [1:0]    accNow;

    task automatic driveInputs();
        req_valid  = {cv[1], cv[0]};
        req_we     = {cwe[1], cwe[0]};
        req_addr0  = caddr[0];
        req_addr1  = caddr[1];
        req_wdata0 = cdata[0];
        req_wdata1 = cdata[1];
    endtask

    task automatic fail(input string name, input string detail);
        failures++;
        $display("[TB] FAIL %s %s (cycle %0d)", name, detail, cyc);
    endtask

    // Replace accepted or idle commands according to the current mode; held commands stay
    task automatic applyStimulus(input logic [1:0] acc);
        for (int k = 0; k < 2; k++) begin
            if (cv[k] && !acc[k]) continue;
            cv[k] = 1'b0; cwe[k] = 1'b0; caddr[k] = '0; cdata[k] = '0;
            case (mode)
                M_FILLW: if (k == 0 && seq < DEPTH) begin
                    cv[k] = 1'b1; cwe[k] = 1'b1; caddr[k] = AW'(seq); cdata[k] = W'(seq); seq++;
                end
                M_FILLR: if (k == 1 && seq < DEPTH) begin
                    cv[k] = 1'b1; caddr[k] = AW'(seq); seq++;
                end
                M_BOTH: begin
                    cv[k] = 1'b1; cwe[k] = 1'($urandom_range(0, 1));
                    caddr[k] = AW'($urandom_range(0, 15)); cdata[k] = W'($urandom);
                end
                M_GAPS: begin
                    cv[k] = ($urandom_range(0, 2) != 0); cwe[k] = 1'($urandom_range(0, 1));
                    caddr[k] = AW'($urandom_range(0, 31)); cdata[k] = W'($urandom);
                end
                M_RAW: if (k == 0 && seq < 2) begin
                    cv[k] = 1'b1; cwe[k] = (seq == 0); caddr[k] = AW'(5); cdata[k] = 18'h2AAAA; seq++;
                end
                M_RD2: if (k == 1 && seq < 2) begin
                    cv[k] = 1'b1; caddr[k] = AW'(100 + seq); seq++;
                end
                M_RD777: if (k == 1 && seq < 1) begin
                    cv[k] = 1'b1; caddr[k] = AW'(777); seq++;
                end
                default: ;
            endcase
        end
        driveInputs();
    endtask

    // Arbitration and RAM-enable checks, then record accepted commands in the model
    task automatic checkOutput(output logic [1:0] acc);
        logic [1:0]    v, r, expR;
        logic [AW-1:0] a;
        v = req_valid;
        r = req_ready;
        expR = 2'b00;
        if (v == 2'b11)  expR = refPtr ? 2'b10 : 2'b01;
        else             expR = v;
        if (v != 2'b00) begin
            checks++;
            if (r !== expR) fail("arb_grant", $sformatf("valid=%b ready=%b expected=%b", v, r, expR));
        end
        checks++;
        if (ram_ena !== prevAny) fail("ram_ena", $sformatf("got=%b expected=%b", ram_ena, prevAny));
        acc = v & r;
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                a = (k == 0) ? req_addr0 : req_addr1;
                if (req_we[k]) refMem[a] = (k == 0) ? req_wdata0 : req_wdata1;
                else sb.push_back('{tag: 2'(1 << k), data: refMem[a], due: cyc + 3});
            end
        end
        prevAny = |acc;
        if (expR != 2'b00) refPtr = expR[0];
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput(accNow);
        @(posedge clk);
        #1;
        applyStimulus(accNow);
    endtask

    task automatic runCycles(input mode_t m, input int n);
        mode = m;
        seq = 0;
        repeat (n) stepCycle();
    endtask

    task automatic doReset(input int n);
        int busyCount;
        bit done;
        rst = 1'b1;
        mode = M_IDLE;
        for (int k = 0; k < 2; k++) begin
            cv[k] = 1'b1; cwe[k] = 1'b0; caddr[k] = '0; cdata[k] = '0;
        end
        driveInputs();
        @(posedge clk);
        #1;
        sb.delete();
        refPtr = 1'b0;
        prevAny = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
        foreach (refMem[i]) refMem[i] = '0;
`endif
        @(negedge clk);
        checks += 7;
        if (ram_ena !== 1'b0)       fail("rst_ram_ena", $sformatf("got=%b expected=0", ram_ena));
        if (ram_wea !== 1'b0)       fail("rst_ram_wea", $sformatf("got=%b expected=0", ram_wea));
        if (ram_addra !== '0)       fail("rst_ram_addra", $sformatf("got=%h expected=0", ram_addra));
        if (ram_dina !== '0)        fail("rst_ram_dina", $sformatf("got=%h expected=0", ram_dina));
        if (rsp_valid !== 2'b00)    fail("rst_rsp_valid", $sformatf("got=%b expected=00", rsp_valid));
        if (req_ready !== 2'b00)    fail("rst_req_ready", $sformatf("got=%b expected=00", req_ready));
        if (busy !== BUSY_IN_RST)   fail("rst_busy", $sformatf("got=%b expected=%b", busy, BUSY_IN_RST));
        repeat (n - 1) @(posedge clk);
        #1;
        rst = 1'b0;
        busyCount = 0;
        done = 1'b0;
        for (int i = 0; i < DEPTH + 64 && !done; i++) begin
            @(negedge clk);
            if (busy) begin
                busyCount++;
                checks++;
                if (req_ready !== 2'b00) fail("clear_ready", $sformatf("got=%b expected=00", req_ready));
            end else begin
                prevAny = (busyCount > 0);
                checkOutput(accNow);
                @(posedge clk);
                #1;
                applyStimulus(accNow);
                done = 1'b1;
            end
        end
        checks++;
        if (!done || busyCount != CLEAR_CYCLES)
            fail("busy_length", $sformatf("got=%0d expected=%0d", busyCount, CLEAR_CYCLES));
    endtask

    // Monitor: pops the scoreboard whenever a response is due or presented
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            fail("rsp_missing", $sformatf("tag=%b due=%0d got no rsp_valid", sb[0].tag, sb[0].due));
            void'(sb.pop_front());
        end
        if (rsp_valid !== 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                fail("rsp_unexpected", $sformatf("rsp_valid=%b expected=00", rsp_valid));
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== e.tag || rsp_data !== e.data || cyc != e.due)
                    fail("rsp_check", $sformatf("valid=%b data=%h cyc=%0d expected valid=%b data=%h cyc=%0d",
                         rsp_valid, rsp_data, cyc, e.tag, e.data, e.due));
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        doReset(3);
        runCycles(M_FILLW, 1030);
        runCycles(M_FILLR, 1030);
        runCycles(M_IDLE, 6);

        doReset(2);
        runCycles(M_BOTH, 300);
        runCycles(M_GAPS, 500);
        runCycles(M_IDLE, 6);

        runCycles(M_RAW, 8);

        runCycles(M_RD2, 3);
        doReset(2);
        runCycles(M_IDLE, 8);

        runCycles(M_RD777, 8);
        runCycles(M_IDLE, 6);

        checks++;
        if (sb.size() != 0) fail("sb_drain", $sformatf("left=%0d expected=0", sb.size()));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
